// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: 128-bit line hits in one cycle,
// misses refilled from a 32-bit memory port in four ascending beats.
module icache #(
   parameter int unsigned NUM_LINES = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [31:0]  pc_in,
   input  logic         cache_rd_en,
   input  logic         cache_abort,
   output logic [127:0] dout,
   output logic         dout_valid,
   output logic         busy,
   output logic         mem_req,
   output logic [31:0]  mem_addr,
   input  logic [31:0]  mem_rdata,
   input  logic         mem_rvalid
);

   localparam int unsigned IDX_W = $clog2(NUM_LINES);
   localparam int unsigned TAG_W = 28 - IDX_W;

   typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} state_t;

   state_t             state_q, state_d;
   logic [1:0]         cnt_q, cnt_d;
   logic               abort_q, abort_d;
   logic               hit_q, hit_d;
   logic [27:0]        line_addr_q, line_addr_d;
   logic [127:0]       fill_q, fill_d;
   logic [127:0]       dout_q, dout_d;
   logic [NUM_LINES-1:0] valid_q, valid_d;

   logic [TAG_W-1:0]   tag_q  [NUM_LINES];
   logic [127:0]       data_q [NUM_LINES];

   logic [IDX_W-1:0]   req_idx, fill_idx;
   logic [TAG_W-1:0]   req_tag, fill_tag;
   logic               req_hit;
   logic               inst_en;
   logic [127:0]       inst_line;
   logic               pc_off_unused;

   assign req_idx       = pc_in[IDX_W+3:4];
   assign req_tag       = pc_in[31:IDX_W+4];
   assign fill_idx      = line_addr_q[IDX_W-1:0];
   assign fill_tag      = line_addr_q[27:IDX_W];
   assign req_hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
   assign inst_line     = {mem_rdata, fill_q[95:0]};
   assign pc_off_unused = ^pc_in[3:0];

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      abort_d     = abort_q;
      hit_d       = 1'b0;
      line_addr_d = line_addr_q;
      fill_d      = fill_q;
      dout_d      = dout_q;
      valid_d     = valid_q;
      inst_en     = 1'b0;

      case (state_q)
         IDLE: begin
            if (cache_rd_en && !cache_abort) begin
               if (req_hit) begin
                  hit_d  = 1'b1;
                  dout_d = data_q[req_idx];
               end else begin
                  line_addr_d = pc_in[31:4];
                  state_d     = REQ;
               end
            end
         end
         REQ: begin
            if (mem_rvalid) begin
               fill_d[31:0] = mem_rdata;
               cnt_d        = 2'd1;
               state_d      = FILL;
            end
         end
         FILL: begin
            if (mem_rvalid) begin
               fill_d[{cnt_q, 5'b0} +: 32] = mem_rdata;
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  // dout register takes the completed line so DONE presents it
                  inst_en           = 1'b1;
                  valid_d[fill_idx] = 1'b1;
                  dout_d            = inst_line;
                  state_d           = DONE;
               end
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if ((state_q == REQ || state_q == FILL) && cache_abort) abort_d = 1'b1;
      if (state_d == IDLE) abort_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         abort_q     <= 1'b0;
         hit_q       <= 1'b0;
         line_addr_q <= '0;
         fill_q      <= '0;
         dout_q      <= '0;
         valid_q     <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         abort_q     <= abort_d;
         hit_q       <= hit_d;
         line_addr_q <= line_addr_d;
         fill_q      <= fill_d;
         dout_q      <= dout_d;
         valid_q     <= valid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (inst_en && !rst) begin
         data_q[fill_idx] <= inst_line;
         tag_q[fill_idx]  <= fill_tag;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = ((state_q == DONE) ? !abort_q : hit_q) && !cache_abort;
   assign busy       = (state_q != IDLE);
   assign mem_req    = (state_q == REQ);
   assign mem_addr   = {line_addr_q, 4'h0};

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: cold miss, hits, conflict, abort, busy ignore and reset mid-refill.
module tb_icache;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [31:0]  pc_in = '0;
   logic         cache_rd_en = 1'b0;
   logic         cache_abort = 1'b0;
   logic [127:0] dout;
   logic         dout_valid;
   logic         busy;
   logic         mem_req;
   logic [31:0]  mem_addr;
   logic [31:0]  mem_rdata = '0;
   logic         mem_rvalid = 1'b0;

   int unsigned pass_cnt = 0;
   int unsigned tot_cnt  = 0;

   localparam logic [127:0] L100 = 128'h00000044_00000033_00000022_00000011;
   localparam logic [127:0] L500 = 128'h000000a4_000000a3_000000a2_000000a1;
   localparam logic [127:0] L200 = 128'h000000b4_000000b3_000000b2_000000b1;
   localparam logic [127:0] L300 = 128'h000000c3_000000c2_000000c1_000000c0;

   icache #(.NUM_LINES(64)) dut (
      .clk(clk), .rst(rst), .pc_in(pc_in), .cache_rd_en(cache_rd_en),
      .cache_abort(cache_abort), .dout(dout), .dout_valid(dout_valid),
      .busy(busy), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   // request for one cycle, then step into the response cycle
   task automatic issue(input logic [31:0] pc);
      pc_in = pc;
      cache_rd_en = 1'b1;
      cyc();
      cache_rd_en = 1'b0;
      #1;
   endtask

   task automatic beat(input logic [31:0] d);
      mem_rdata = d;
      mem_rvalid = 1'b1;
      cyc();
      mem_rvalid = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cyc(); cyc();
      #1;
      tot_cnt++; if (dout !== '0) $display("FAIL reset_dout: got %h want 0", dout); else pass_cnt++;
      tot_cnt++; if (dout_valid !== 1'b0) $display("FAIL reset_dv: got %b want 0", dout_valid); else pass_cnt++;
      tot_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
      tot_cnt++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req: got %b want 0", mem_req); else pass_cnt++;
      tot_cnt++; if (mem_addr !== 32'h0) $display("FAIL reset_mem_addr: got %h want 0", mem_addr); else pass_cnt++;
      rst = 1'b0;
      cyc();
   endtask

   task automatic test_cold_miss();
      pc_in = 32'h100;
      cache_rd_en = 1'b1;
      #1;
      tot_cnt++; if (busy !== 1'b0) $display("FAIL cold_busy_t0: got %b want 0", busy); else pass_cnt++;
      cyc();
      cache_rd_en = 1'b0;
      #1;
      tot_cnt++; if (mem_req !== 1'b1) $display("FAIL cold_mem_req: got %b want 1", mem_req); else pass_cnt++;
      tot_cnt++; if (mem_addr !== 32'h100) $display("FAIL cold_mem_addr: got %h want 100", mem_addr); else pass_cnt++;
      tot_cnt++; if (busy !== 1'b1) $display("FAIL cold_busy: got %b want 1", busy); else pass_cnt++;
      beat(32'h11);
      tot_cnt++; if (mem_req !== 1'b0) $display("FAIL cold_req_drop: got %b want 0", mem_req); else pass_cnt++;
      beat(32'h22);
      beat(32'h33);
      tot_cnt++; if (dout_valid !== 1'b0) $display("FAIL cold_dv_early: got %b want 0", dout_valid); else pass_cnt++;
      beat(32'h44);
      tot_cnt++; if (dout_valid !== 1'b1) $display("FAIL cold_dv: got %b want 1", dout_valid); else pass_cnt++;
      tot_cnt++; if (dout !== L100) $display("FAIL cold_dout: got %h want %h", dout, L100); else pass_cnt++;
      cyc();
      #1;
      tot_cnt++; if (dout_valid !== 1'b0) $display("FAIL cold_dv_pulse: got %b want 0", dout_valid); else pass_cnt++;
      tot_cnt++; if (busy !== 1'b0) $display("FAIL cold_busy_end: got %b want 0", busy); else pass_cnt++;
   endtask

   task automatic test_hit();
      issue(32'h10c);
      tot_cnt++; if (dout_valid !== 1'b1) $display("FAIL hit_dv: got %b want 1", dout_valid); else pass_cnt++;
      tot_cnt++; if (dout !== L100) $display("FAIL hit_dout: got %h want %h", dout, L100); else pass_cnt++;
      tot_cnt++; if (mem_req !== 1'b0 || busy !== 1'b0) $display("FAIL hit_no_req: got req=%b busy=%b want 0 0", mem_req, busy); else pass_cnt++;
      cyc();
      pc_in = 32'h100;
      cache_rd_en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cyc();
         pc_in = 32'h100 + 32'(4 * ((i + 1) % 4));
         if (i == 5) cache_rd_en = 1'b0;
         #1;
         tot_cnt++; if (dout_valid !== 1'b1 || mem_req !== 1'b0) $display("FAIL b2b_hit_%0d: got dv=%b req=%b want 1 0", i, dout_valid, mem_req); else pass_cnt++;
      end
      cyc();
      #1;
      tot_cnt++; if (dout_valid !== 1'b0) $display("FAIL b2b_end: got %b want 0", dout_valid); else pass_cnt++;
   endtask

   task automatic test_conflict();
      issue(32'h500);
      tot_cnt++; if (mem_req !== 1'b1 || mem_addr !== 32'h500) $display("FAIL conf_miss: got req=%b addr=%h want 1 500", mem_req, mem_addr); else pass_cnt++;
      cyc();
      #1;
      tot_cnt++; if (mem_req !== 1'b1) $display("FAIL conf_req_held: got %b want 1", mem_req); else pass_cnt++;
      beat(32'ha1);
      cyc();
      #1;
      beat(32'ha2);
      beat(32'ha3);
      beat(32'ha4);
      tot_cnt++; if (dout_valid !== 1'b1 || dout !== L500) $display("FAIL conf_fill: got dv=%b dout=%h want 1 %h", dout_valid, dout, L500); else pass_cnt++;
      cyc();
      issue(32'h100);
      tot_cnt++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) $display("FAIL conf_evicted: got req=%b addr=%h want 1 100", mem_req, mem_addr); else pass_cnt++;
      beat(32'h11); beat(32'h22); beat(32'h33); beat(32'h44);
      tot_cnt++; if (dout_valid !== 1'b1 || dout !== L100) $display("FAIL conf_refill: got dv=%b dout=%h want 1 %h", dout_valid, dout, L100); else pass_cnt++;
      cyc();
   endtask

   task automatic test_abort();
      issue(32'h200);
      tot_cnt++; if (mem_req !== 1'b1 || mem_addr !== 32'h200) $display("FAIL abort_miss: got req=%b addr=%h want 1 200", mem_req, mem_addr); else pass_cnt++;
      beat(32'hb1);
      beat(32'hb2);
      cache_abort = 1'b1;
      cyc();
      cache_abort = 1'b0;
      #1;
      beat(32'hb3);
      beat(32'hb4);
      tot_cnt++; if (dout_valid !== 1'b0 || busy !== 1'b1) $display("FAIL abort_done: got dv=%b busy=%b want 0 1", dout_valid, busy); else pass_cnt++;
      cyc();
      #1;
      tot_cnt++; if (busy !== 1'b0 || dout_valid !== 1'b0) $display("FAIL abort_idle: got busy=%b dv=%b want 0 0", busy, dout_valid); else pass_cnt++;
      issue(32'h200);
      tot_cnt++; if (dout_valid !== 1'b1 || dout !== L200 || mem_req !== 1'b0) $display("FAIL abort_installed: got dv=%b dout=%h req=%b want 1 %h 0", dout_valid, dout, mem_req, L200); else pass_cnt++;
      cyc();
      issue(32'h204);
      cache_abort = 1'b1;
      #1;
      tot_cnt++; if (dout_valid !== 1'b0) $display("FAIL abort_hit_kill: got %b want 0", dout_valid); else pass_cnt++;
      cache_abort = 1'b0;
      cyc();
      pc_in = 32'h700;
      cache_rd_en = 1'b1;
      cache_abort = 1'b1;
      cyc();
      cache_rd_en = 1'b0;
      cache_abort = 1'b0;
      #1;
      tot_cnt++; if (busy !== 1'b0 || mem_req !== 1'b0 || dout_valid !== 1'b0) $display("FAIL abort_req_drop: got busy=%b req=%b dv=%b want 0 0 0", busy, mem_req, dout_valid); else pass_cnt++;
   endtask

   task automatic test_busy_ignore();
      int unsigned req_cycles = 0;
      int unsigned dv_cycles = 0;
      pc_in = 32'h300;
      cache_rd_en = 1'b1;
      cyc();
      for (int k = 0; k < 4; k++) begin
         pc_in = 32'h310 + 32'(16 * k);
         mem_rdata = 32'hc0 + 32'(k);
         mem_rvalid = 1'b1;
         #1;
         if (mem_req) req_cycles++;
         if (dout_valid) dv_cycles++;
         cyc();
      end
      cache_rd_en = 1'b0;
      mem_rvalid = 1'b0;
      #1;
      tot_cnt++; if (dout_valid !== 1'b1 || dout !== L300) $display("FAIL busy_resp: got dv=%b dout=%h want 1 %h", dout_valid, dout, L300); else pass_cnt++;
      tot_cnt++; if (req_cycles !== 1 || dv_cycles !== 0) $display("FAIL busy_counts: got req=%0d dv=%0d want 1 0", req_cycles, dv_cycles); else pass_cnt++;
      cyc();
      #1;
      tot_cnt++; if (busy !== 1'b0 || mem_req !== 1'b0) $display("FAIL busy_end: got busy=%b req=%b want 0 0", busy, mem_req); else pass_cnt++;
      issue(32'h310);
      tot_cnt++; if (mem_req !== 1'b1 || mem_addr !== 32'h310) $display("FAIL busy_not_queued: got req=%b addr=%h want 1 310", mem_req, mem_addr); else pass_cnt++;
      beat(32'hd0); beat(32'hd1); beat(32'hd2); beat(32'hd3);
      cyc();
   endtask

   task automatic test_reset_mid();
      issue(32'h800);
      beat(32'he0);
      beat(32'he1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      #1;
      tot_cnt++; if (mem_req !== 1'b0 || busy !== 1'b0) $display("FAIL rstmid_idle: got req=%b busy=%b want 0 0", mem_req, busy); else pass_cnt++;
      issue(32'h100);
      tot_cnt++; if (mem_req !== 1'b1 || dout_valid !== 1'b0) $display("FAIL rstmid_miss: got req=%b dv=%b want 1 0", mem_req, dout_valid); else pass_cnt++;
      beat(32'h11); beat(32'h22); beat(32'h33); beat(32'h44);
      tot_cnt++; if (dout_valid !== 1'b1 || dout !== L100) $display("FAIL rstmid_refill: got dv=%b dout=%h want 1 %h", dout_valid, dout, L100); else pass_cnt++;
      cyc();
      issue(32'h800);
      tot_cnt++; if (mem_req !== 1'b1 || mem_addr !== 32'h800) $display("FAIL rstmid_partial: got req=%b addr=%h want 1 800", mem_req, mem_addr); else pass_cnt++;
      rst = 1'b1;
      cyc();
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_cold_miss();
      test_hit();
      test_conflict();
      test_abort();
      test_busy_ignore();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache directly upstream of the instruction fetch queue. Accepts fetch requests for 16-byte lines, returns a full 128-bit line on a hit one cycle later, and on a miss refills the line from a 32-bit memory port in four beats. Supports aborting a pending response when fetch redirects on a jump or branch.

## Interface
- NUM_LINES, 64, number of 16-byte lines; power of two, ≥2; IDX_W = log2(NUM_LINES)
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- pc_in  in  32  fetch address; bits [3:0] ignored
- cache_rd_en  in  1  fetch request; sampled only when busy=0
- cache_abort  in  1  cancel any response not yet delivered
- dout  out  128  line data; word k (pc offset 4k) at bits [32k+31:32k]
- dout_valid  out  1  dout valid this cycle; single-cycle pulse per response
- busy  out  1  miss in progress; requests ignored while high
- mem_req  out  1  line refill request; held until first mem_rvalid
- mem_addr  out  32  refill address, {pc[31:4],4'h0}
- mem_rdata  in  32  refill beat data
- mem_rvalid  in  1  refill beat valid; beats arrive in ascending word order, gaps allowed

## Operation
- Address split: offset pc[3:0], index pc[IDX_W+3:4], tag pc[31:IDX_W+4].
- Storage: per line a valid bit, tag, and 128-bit data in register arrays; read combinationally in the request cycle.
- FSM states: IDLE, REQ, FILL, DONE. busy = (state != IDLE).
- IDLE, cache_rd_en=1, cache_abort=0:
  - Hit (valid & tag match): register line; dout_valid=1 next cycle; stay IDLE.
  - Miss: latch line address; go to REQ.
- IDLE, cache_rd_en=1, cache_abort=1: request dropped; no response, no refill.
- REQ: mem_req=1, mem_addr = latched line address. On mem_rvalid, capture beat 0 and go to FILL with beat counter = 1.
- FILL: mem_req=0. Each mem_rvalid writes word[counter] into the fill buffer and increments the 2-bit counter. On the 4th beat, write data, tag, and valid=1 into the indexed line at that clock edge, then go to DONE.
- DONE: dout = fill buffer; dout_valid=1 unless the abort flag is set or cache_abort=1. Return to IDLE next cycle.
- The abort flag is set by cache_abort in REQ or FILL and cleared on entering IDLE. An aborted refill still completes and installs the line.
- cache_abort=1 in any cycle forces dout_valid=0 in that cycle, including a registered hit response.
- Requests in REQ, FILL, or DONE are ignored and not queued. The requester must re-issue after busy falls.
- mem_rvalid outside REQ and FILL is ignored.
- A refill replaces the resident line at its index unconditionally. There is no write path.

## Timing
- Reset values: dout=0, dout_valid=0, busy=0, mem_req=0, mem_addr=0, state=IDLE, counter=0, abort flag=0, all valid bits=0. Data and tag arrays are not reset.
- Hit latency: request at cycle T gives dout_valid at T+1. Back-to-back hits sustain one line per cycle.
- Miss: request at T → busy=1 and mem_req=1 from T+1. 4th beat at cycle B → line installed at the B edge, DONE (dout_valid) at B+1, IDLE at B+2. The earliest new request is at B+2.
- Minimum miss latency with zero-gap memory returning its first beat at T+1: dout_valid at T+5.
- rst mid-refill: next cycle is IDLE with mem_req=0; the partial line is discarded and the target line stays invalid.
- dout holds its last value when dout_valid=0.

## Test plan
- Cold miss: after reset, rd_en with pc=0x100 → at T+1 mem_req=1, mem_addr=0x100. Beats 0x11,0x22,0x33,0x44 → one cycle after the last beat, dout_valid=1 and dout=0x00000044_00000033_00000022_00000011.
- Hit: then rd_en with pc=0x10C → dout_valid at T+1 with the same line; mem_req stays 0. Six consecutive hits give six consecutive dout_valid cycles.
- Conflict (NUM_LINES=64): fill 0x100, then fetch 0x500 → miss with mem_addr=0x500, which replaces the line. Fetching 0x100 again → miss.
- Abort: miss on 0x200, cache_abort during FILL after beat 2 → no dout_valid in DONE. A following fetch of 0x200 hits at T+1.
- Busy ignore: hold rd_en=1 with pc stepping 0x300, 0x310, … during a miss on 0x300 → exactly one mem_req. Only the 0x300 response is delivered.
- Reset mid-refill: rst after beat 2 → mem_req=0 and busy=0 next cycle. Fetching 0x100 after reset → miss.
